// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side packer.
package fifo_pkg;

    localparam int FIFO_DATA_W = 4;
    localparam int FIFO_PACK   = 2;

    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    localparam int FIFO_CNT_W = clog2_f(FIFO_PACK + 1);

    // One packed output beat for the default configuration.
    typedef struct packed {
        logic [FIFO_CNT_W-1:0]            cnt;
        logic [FIFO_DATA_W*FIFO_PACK-1:0] data;
    } beat_t;

endpackage

// File: rtl/fifo_out_slice.sv
// Single-entry valid/ready output register; slot_free says a new beat may load this cycle.
module fifo_out_slice #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic [CNT_W-1:0]     cnt_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic [CNT_W-1:0]     cnt_o,
    output logic                 slot_free_o
);

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            cnt_d   = cnt_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign cnt_o       = cnt_q;
    assign slot_free_o = !valid_q || ready_i;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words (read latency 1) and packs PACK of them, first word in the low
// bits, into one output beat; a flush emits a partially filled, zero-padded beat.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W,
    parameter  int PACK   = 2,
    localparam int CNT_W  = clog2_f(PACK + 1)
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic                     fifo_empty,
    input  logic [DATA_W-1:0]        fifo_rd_data,
    output logic                     fifo_rd_en,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W*PACK-1:0]   out_data,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     busy
);

    logic [CNT_W-1:0]       fill_q, fill_d;
    logic                   inflight_q;
    logic                   flush_pend_q, flush_pend_d;
    logic                   slot_free, full_load, flush_load, load, pop;
    logic [CNT_W:0]         pending;
    logic [DATA_W*PACK-1:0] acc_flat;

    // Words already captured plus the word landing this cycle.
    assign pending    = {1'b0, fill_q} + {{CNT_W{1'b0}}, inflight_q};
    assign full_load  = (fill_q == CNT_W'(PACK)) && slot_free;
    assign flush_load = flush_pend_q && !inflight_q && slot_free;
    assign load       = full_load || flush_load;

    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && !flush_pend_q && !rd_rst) begin
            pop = (pending < (CNT_W+1)'(PACK)) || full_load;
        end

        fill_d = fill_q;
        if (load) begin
            fill_d = '0;
        end else if (inflight_q) begin
            fill_d = fill_q + CNT_W'(1);
        end

        // A flush coinciding with a load stays pending only if a word is being popped now.
        flush_pend_d = flush_pend_q;
        if (load) begin
            flush_pend_d = flush && pop;
        end else if (flush && (pending != '0)) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            fill_q       <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            inflight_q   <= pop;
            flush_pend_q <= flush_pend_d;
        end
    end

    for (genvar gi = 0; gi < PACK; gi++) begin : g_slot
        logic [DATA_W-1:0] slot_q;

        always_ff @(posedge rd_clk or posedge rd_rst) begin
            if (rd_rst) begin
                slot_q <= '0;
            end else if (load) begin
                slot_q <= '0;
            end else if (inflight_q && (fill_q == CNT_W'(gi))) begin
                slot_q <= fifo_rd_data;
            end
        end

        assign acc_flat[gi*DATA_W +: DATA_W] = (CNT_W'(gi) < fill_q) ? slot_q : '0;
    end

    fifo_out_slice #(
        .DATA_BITS (DATA_W*PACK),
        .CNT_W     (CNT_W)
    ) u_out (
        .clk_i       (rd_clk),
        .rst_i       (rd_rst),
        .load_i      (load),
        .data_i      (acc_flat),
        .cnt_i       (fill_q),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .cnt_o       (out_cnt),
        .slot_free_o (slot_free)
    );

    assign fifo_rd_en = pop;
    assign busy       = (pending != '0) || flush_pend_q;

    // A landing word must always find a free accumulator slot.
    always @(posedge rd_clk) begin
        if (!rd_rst && inflight_q) begin
            assert (fill_q < CNT_W'(PACK));
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural latency-1 FIFO model.
module tb_fifo_rd_packer;

    localparam int DATA_W = 4;
    localparam int PACK   = 2;
    localparam int CNT_W  = 2;

    logic                   rd_clk = 1'b0;
    logic                   rd_rst = 1'b1;
    logic                   fifo_empty;
    logic [DATA_W-1:0]      fifo_rd_data = '0;
    logic                   fifo_rd_en;
    logic                   flush = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [DATA_W*PACK-1:0] out_data;
    logic [CNT_W-1:0]       out_cnt;
    logic                   busy;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_rd_packer dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_cnt      (out_cnt),
        .busy         (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: data appears one cycle after the pop; reset empties it.
    logic [DATA_W-1:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            pops         <= pops + 1;
        end
    end

    // Record every accepted beat.
    logic [DATA_W*PACK-1:0] beat_data [64];
    logic [CNT_W-1:0]       beat_cnt  [64];
    int nb = 0;

    always @(posedge rd_clk) begin
        if (!rd_rst && out_valid && out_ready) begin
            beat_data[nb] <= out_data;
            beat_cnt[nb]  <= out_cnt;
            nb            <= nb + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (nb < target && k < budget) begin
            @(negedge rd_clk);
            k++;
        end
        chk(tag, nb >= target, 1'b1);
    endtask

    task automatic check_beat(input int idx, input logic [7:0] exp_d, input logic [1:0] exp_c,
                              input string tag);
        chk({tag, "_data"}, beat_data[idx], exp_d);
        chk({tag, "_cnt"}, beat_cnt[idx], exp_c);
        $display("beat %0d: data=%02h cnt=%0d (%s)", idx, beat_data[idx], beat_cnt[idx], tag);
    endtask

    initial begin
        int b0, p0, k, idle, max_idle;
        bit seen;
        logic [7:0] exp_d;

        // Reset state
        repeat (2) @(negedge rd_clk);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_cnt", out_cnt, 2'd0);
        chk("rst_busy", busy, 1'b0);
        rd_rst = 1'b0;
        @(negedge rd_clk);

        // 1: four words, ready high
        out_ready = 1'b1;
        b0 = nb; p0 = pops;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        wait_beats(b0 + 2, 30, "t1_timeout");
        check_beat(b0, 8'h21, 2'd2, "t1_b0");
        check_beat(b0 + 1, 8'h43, 2'd2, "t1_b1");
        repeat (3) @(negedge rd_clk);
        chk("t1_empty", fifo_empty, 1'b1);
        chk("t1_rd_en", fifo_rd_en, 1'b0);
        chk("t1_pops", pops - p0, 4);
        chk("t1_busy", busy, 1'b0);

        // 2: four words with ready held low for 10 cycles
        out_ready = 1'b0;
        b0 = nb; p0 = pops;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        repeat (6) @(negedge rd_clk);
        chk("t2_hold_data_early", out_data, 8'h21);
        repeat (4) @(negedge rd_clk);
        chk("t2_pops", pops - p0, 4);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_hold_data", out_data, 8'h21);
        chk("t2_hold_cnt", out_cnt, 2'd2);
        chk("t2_busy", busy, 1'b1);
        out_ready = 1'b1;
        @(negedge rd_clk);
        chk("t2_b2b_valid", out_valid, 1'b1);
        chk("t2_b2b_data", out_data, 8'h43);
        @(negedge rd_clk);
        chk("t2_drop_valid", out_valid, 1'b0);
        chk("t2_beats", nb - b0, 2);
        check_beat(b0, 8'h21, 2'd2, "t2_b0");
        check_beat(b0 + 1, 8'h43, 2'd2, "t2_b1");

        // 3: idle flush is ignored, then a single word flushed out
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        repeat (3) @(negedge rd_clk);
        chk("t3_idle_flush_valid", out_valid, 1'b0);
        chk("t3_idle_flush_busy", busy, 1'b0);
        b0 = nb;
        push(4'h5);
        repeat (3) @(negedge rd_clk);
        chk("t3_busy_partial", busy, 1'b1);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_beats(b0 + 1, 10, "t3_timeout");
        check_beat(b0, 8'h05, 2'd1, "t3_b0");
        @(negedge rd_clk);
        chk("t3_busy_done", busy, 1'b0);

        // 4: flush while a word is in flight; no pop during the pending window
        b0 = nb; p0 = pops;
        push(4'h9);
        @(negedge rd_clk);
        chk("t4_pop_issued", pops - p0, 1);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        push(4'hA);
        chk("t4_no_pop_pending", fifo_rd_en, 1'b0);
        chk("t4_busy_pending", busy, 1'b1);
        @(negedge rd_clk);
        chk("t4_valid", out_valid, 1'b1);
        chk("t4_data", out_data, 8'h09);
        chk("t4_cnt", out_cnt, 2'd1);
        chk("t4_pops_window", pops - p0, 1);
        repeat (3) @(negedge rd_clk);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_beats(b0 + 2, 10, "t4_timeout");
        check_beat(b0, 8'h09, 2'd1, "t4_b0");
        check_beat(b0 + 1, 8'h0A, 2'd1, "t4_b1");

        // 5: sixteen words streamed through
        b0 = nb; seen = 1'b0; idle = 0; max_idle = 0; k = 0;
        for (int i = 0; i < 16; i++) push(4'(i));
        while (nb < b0 + 8 && k < 100) begin
            @(negedge rd_clk);
            k++;
            if (out_valid) begin
                if (seen && idle > max_idle) max_idle = idle;
                seen = 1'b1;
                idle = 0;
            end else if (seen) begin
                idle++;
            end
        end
        chk("t5_beats", nb - b0, 8);
        chk("t5_max_gap_ok", max_idle <= PACK, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_d = {4'(2 * i + 1), 4'(2 * i)};
            check_beat(b0 + i, exp_d, 2'd2, "t5_beat");
        end

        // 6: asynchronous reset mid-operation, then fresh data
        repeat (3) @(negedge rd_clk);
        out_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3);
        repeat (8) @(negedge rd_clk);
        chk("t6_pre_valid", out_valid, 1'b1);
        chk("t6_pre_data", out_data, 8'h21);
        chk("t6_pre_busy", busy, 1'b1);
        rd_rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_data", out_data, 8'h00);
        chk("t6_rst_cnt", out_cnt, 2'd0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_rd_en", fifo_rd_en, 1'b0);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        @(negedge rd_clk);
        out_ready = 1'b1;
        b0 = nb;
        push(4'h7); push(4'h8);
        wait_beats(b0 + 1, 20, "t6_timeout");
        check_beat(b0, 8'h87, 2'd2, "t6_b0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
